// File: rtl/sig_exp_pkg.sv
// Shared types for multi_signal_expansioner: per-channel state encoding and the runtime config word.
package sig_exp_pkg;

    localparam int CFG_LEN_W = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_DEAD   = ST_DEAD
    } ch_state_e;

    typedef struct packed {
        logic [CFG_LEN_W-1:0] extend_len;
        logic [CFG_LEN_W-1:0] dead_len;
        logic                 retrig;
    } cfg_t;

    // Counters run len-1 down to 0, so a phase lasts exactly len cycles.
    function automatic logic [CFG_LEN_W-1:0] len_to_cnt(input logic [CFG_LEN_W-1:0] len);
        return len - 1'b1;
    endfunction

endpackage

// File: rtl/sig_exp_channel.sv
// One pulse-stretcher channel: edge detect, IDLE/ACTIVE/DEAD FSM and phase counter.
// With HIT_COUNTER_EN defined it also keeps a saturating count of accepted edges.
module sig_exp_channel
    import sig_exp_pkg::*;
`ifdef HIT_COUNTER_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  cfg_t      cfg_i,
    input  logic      en_i,
    input  logic      sig_i,
`ifdef HIT_COUNTER_EN
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] hit_cnt_o,
`endif
    output logic      sig_o,
    output logic      drop_o,
    output ch_state_e state_o
);

    logic                 sig_d_q;
    logic                 sig_out_q, sig_out_d;
    logic                 drop_q, drop_d;
    logic [CFG_LEN_W-1:0] cnt_q, cnt_d;
    ch_state_e            state_q, state_d;
    logic                 edge_w, can_take_w, take_w;

    assign edge_w = sig_i & ~sig_d_q;

    // A DEAD phase on its last cycle may hand over directly to a new pulse.
    assign can_take_w = (state_q == S_IDLE)
                     || (state_q == S_DEAD && cnt_q == '0)
                     || (state_q == S_ACTIVE && cfg_i.retrig);
    assign take_w = en_i && edge_w && (cfg_i.extend_len != '0) && can_take_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        if (!en_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (take_w) begin
            state_d = S_ACTIVE;
            cnt_d   = len_to_cnt(cfg_i.extend_len);
        end else begin
            drop_d = edge_w;
            case (state_q)
                S_ACTIVE: begin
                    if (cnt_q == '0) begin
                        if (cfg_i.dead_len != '0) begin
                            state_d = S_DEAD;
                            cnt_d   = len_to_cnt(cfg_i.dead_len);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DEAD: begin
                    if (cnt_q == '0) state_d = S_IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        sig_out_d = (state_d == S_ACTIVE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_d_q   <= 1'b0;
            sig_out_q <= 1'b0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
        end else begin
            sig_d_q   <= sig_i;
            sig_out_q <= sig_out_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

`ifdef HIT_COUNTER_EN
    logic [CNT_W-1:0] hit_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                     hit_q <= '0;
        else if (cnt_clr_i)              hit_q <= '0;
        else if (take_w && !(&hit_q))    hit_q <= hit_q + 1'b1;
    end

    assign hit_cnt_o = hit_q;
`endif

    assign sig_o   = sig_out_q;
    assign drop_o  = drop_q;
    assign state_o = state_q;

endmodule

// File: rtl/multi_signal_expansioner.sv
// N-channel pulse stretcher: config registers with valid/ready load, and NUM_CH channels.
// Optional build macro HIT_COUNTER_EN adds CNT_CLR / HIT_CNT per-channel hit counters.
module multi_signal_expansioner
    import sig_exp_pkg::*;
#(
    parameter int NUM_CH               = 4,
    parameter int MAX_EXTEND_LEN_WIDTH = CFG_LEN_W,
    parameter int DEF_EXTEND_LEN       = 4,
    parameter int DEF_DEAD_LEN         = 0,
    parameter int DEF_RETRIG           = 0,
    parameter int HIT_CNT_WIDTH        = 16
)
(
    input  logic                            CLK,
    input  logic                            RESETN,
    input  logic                            CFG_VALID,
    output logic                            CFG_READY,
    input  logic [MAX_EXTEND_LEN_WIDTH-1:0] CFG_EXTEND_LEN,
    input  logic [MAX_EXTEND_LEN_WIDTH-1:0] CFG_DEAD_LEN,
    input  logic                            CFG_RETRIG,
    input  logic [NUM_CH-1:0]               CH_ENABLE,
    input  logic [NUM_CH-1:0]               SIG_IN,
`ifdef HIT_COUNTER_EN
    input  logic                            CNT_CLR,
    output logic [NUM_CH*HIT_CNT_WIDTH-1:0] HIT_CNT,
`endif
    output logic [NUM_CH-1:0]               SIG_OUT,
    output logic [NUM_CH-1:0]               BUSY,
    output logic [NUM_CH-1:0]               DROP_PULSE
);

    cfg_t      cfg_q, cfg_d;
    logic      ready_q, ready_d;
    ch_state_e ch_state [NUM_CH];

    // Handshake: a word is taken on any edge where CFG_VALID && CFG_READY; the master
    // holds it stable otherwise. READY is ~|BUSY registered, so it lags BUSY by one cycle.
    always_comb begin
        ready_d = ~|BUSY;
        cfg_d   = cfg_q;
        if (CFG_VALID && ready_q) begin
            cfg_d.extend_len = CFG_EXTEND_LEN;
            cfg_d.dead_len   = CFG_DEAD_LEN;
            cfg_d.retrig     = CFG_RETRIG;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ready_q          <= 1'b0;
            cfg_q.extend_len <= CFG_LEN_W'(DEF_EXTEND_LEN);
            cfg_q.dead_len   <= CFG_LEN_W'(DEF_DEAD_LEN);
            cfg_q.retrig     <= (DEF_RETRIG != 0);
        end else begin
            ready_q <= ready_d;
            cfg_q   <= cfg_d;
        end
    end

    assign CFG_READY = ready_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sig_exp_channel
`ifdef HIT_COUNTER_EN
        #(.CNT_W(HIT_CNT_WIDTH))
`endif
        u_ch (
            .clk_i     (CLK),
            .rst_ni    (RESETN),
            .cfg_i     (cfg_q),
            .en_i      (CH_ENABLE[i]),
            .sig_i     (SIG_IN[i]),
`ifdef HIT_COUNTER_EN
            .cnt_clr_i (CNT_CLR),
            .hit_cnt_o (HIT_CNT[i*HIT_CNT_WIDTH +: HIT_CNT_WIDTH]),
`endif
            .sig_o     (SIG_OUT[i]),
            .drop_o    (DROP_PULSE[i]),
            .state_o   (ch_state[i])
        );

        assign BUSY[i] = (ch_state[i] != S_IDLE);
    end

endmodule

// File: tb/tb_multi_signal_expansioner.sv
// Scoreboard bench for multi_signal_expansioner: directed steps push expected output vectors,
// a monitor pops and compares them one cycle later.
module tb_multi_signal_expansioner;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        CFG_VALID = 1'b0;
    logic        CFG_READY;
    logic [4:0]  CFG_EXTEND_LEN = 5'd4;
    logic [4:0]  CFG_DEAD_LEN = 5'd0;
    logic        CFG_RETRIG = 1'b0;
    logic [3:0]  CH_ENABLE = 4'hF;
    logic [3:0]  SIG_IN = 4'h0;
    logic [3:0]  SIG_OUT, BUSY, DROP_PULSE;
`ifdef HIT_COUNTER_EN
    logic        CNT_CLR = 1'b0;
    logic [63:0] HIT_CNT;
`endif

    logic [12:0] exp_q[$];
    int          lbl_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          step_no = 0;
    logic        rst_v = 1'b0;

    multi_signal_expansioner dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .CFG_VALID      (CFG_VALID),
        .CFG_READY      (CFG_READY),
        .CFG_EXTEND_LEN (CFG_EXTEND_LEN),
        .CFG_DEAD_LEN   (CFG_DEAD_LEN),
        .CFG_RETRIG     (CFG_RETRIG),
        .CH_ENABLE      (CH_ENABLE),
        .SIG_IN         (SIG_IN),
`ifdef HIT_COUNTER_EN
        .CNT_CLR        (CNT_CLR),
        .HIT_CNT        (HIT_CNT),
`endif
        .SIG_OUT        (SIG_OUT),
        .BUSY           (BUSY),
        .DROP_PULSE     (DROP_PULSE)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step(input logic [3:0] sig, input logic [3:0] en, input logic valid,
                        input logic [3:0] es, input logic [3:0] eb, input logic [3:0] ed,
                        input logic er);
        @(negedge CLK);
        RESETN    = rst_v;
        SIG_IN    = sig;
        CH_ENABLE = en;
        CFG_VALID = valid;
        step_no++;
        exp_q.push_back({er, ed, eb, es});
        lbl_q.push_back(step_no);
    endtask

    task automatic cfg(input logic [4:0] len, input logic [4:0] dead, input logic retrig);
        CFG_EXTEND_LEN = len;
        CFG_DEAD_LEN   = dead;
        CFG_RETRIG     = retrig;
    endtask

    // scoreboard monitor
    initial begin
        logic [12:0] e;
        logic [12:0] got;
        int          lbl;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                lbl = lbl_q.pop_front();
                got = {CFG_READY, DROP_PULSE, BUSY, SIG_OUT};
                n_checks++;
                if (got === e) n_pass++;
                else $display("FAIL step%0d: got rdy=%b drop=%h busy=%h out=%h, expected rdy=%b drop=%h busy=%h out=%h",
                              lbl, got[12], got[11:8], got[7:4], got[3:0], e[12], e[11:8], e[7:4], e[3:0]);
            end
        end
    end

    initial begin
        // reset held, then first edge after release raises READY
        repeat (3) step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        rst_v = 1'b1;
        repeat (3) step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

        // default config: len 4, level held two cycles gives one pulse
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1);
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

        // non-retrigger: second edge dropped
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1);
        step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

        // retrigger: edges at t=0 and t=3 give 7 high cycles
        cfg(5'd4, 5'd0, 1'b1);
        step(4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1);
        step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        repeat (3) step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

        // dead time: len 2, dead 3, edges at t=0,3,5
        cfg(5'd2, 5'd3, 1'b0);
        step(4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1);
        step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0);
        step(4'h1, 4'hF, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0);
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        repeat (3) step(4'h0, 4'hF, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

        // handshake: len 6 offered while ch1 busy; ch0 still gets old len 4
        cfg(5'd4, 5'd0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h2, 4'hF, 1'b0, 4'h2, 4'h2, 4'h0, 1'b1);
        step(4'h0, 4'hF, 1'b0, 4'h2, 4'h2, 4'h0, 1'b0);
        cfg(5'd6, 5'd0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 4'h2, 4'h2, 4'h0, 1'b0);
        step(4'h1, 4'hF, 1'b1, 4'h3, 4'h3, 4'h0, 1'b0);
        repeat (3) step(4'h0, 4'hF, 1'b1, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1);
        repeat (5) step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

        // enable drop mid-pulse, disabled edge, zero-length drop
        step(4'h4, 4'hF, 1'b0, 4'h4, 4'h4, 4'h0, 1'b1);
        step(4'h0, 4'hF, 1'b0, 4'h4, 4'h4, 4'h0, 1'b0);
        step(4'h0, 4'hB, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h8, 4'h7, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        cfg(5'd0, 5'd0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h1, 4'hF, 1'b0, 4'h0, 4'h0, 4'h1, 1'b1);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

        // asynchronous reset mid-pulse
        cfg(5'd4, 5'd0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1);
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        @(posedge CLK);
        #3;
        rst_v  = 1'b0;
        RESETN = 1'b0;
        #1;
        n_checks++;
        if (SIG_OUT === 4'h0 && BUSY === 4'h0 && CFG_READY === 1'b0) n_pass++;
        else $display("FAIL async_reset: got out=%h busy=%h rdy=%b, expected out=0 busy=0 rdy=0",
                      SIG_OUT, BUSY, CFG_READY);
        repeat (2) step(4'h1, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        rst_v = 1'b1;
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        // config back to defaults (len 4)
        step(4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1);
        repeat (3) step(4'h0, 4'hF, 1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

        // final report
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
